// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RISC-V fetch front end: PC generation, imem requests, instruction buffer
// Note: rst_n is active-high despite its name (1 = reset).
module instr_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_WAIT  = 1'b1;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [0:0]      state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            drop;

  logic [31:0]     buf_inst [FIFO_DEPTH];
  logic [XLEN-1:0] buf_pc   [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic hs;
  logic push;
  logic pop;

  // Reset gates the request combinationally so nothing is accepted while it is held.
  assign imem_req_valid = !rst_n && (state == S_FETCH) && (count < CW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign hs   = imem_req_valid && imem_req_ready;
  assign push = (state == S_WAIT) && imem_rsp_valid && !drop && !redirect_valid;
  assign pop  = inst_valid && !stall;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC & ALIGN_MASK;
      req_pc   <= RESET_PC & ALIGN_MASK;
      // Remember an outstanding request until its response has been seen, even across a long reset.
      drop     <= ((state == S_WAIT) || drop) && !imem_rsp_valid;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ALIGN_MASK;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      if (state == S_FETCH) begin
        if (hs) begin
          state <= S_WAIT;
          drop  <= 1'b1;
        end
      end else begin
        if (imem_rsp_valid) begin
          state <= S_FETCH;
          drop  <= 1'b0;
        end else begin
          drop  <= 1'b1;
        end
      end
    end else begin
      if (state == S_FETCH) begin
        if (drop && imem_rsp_valid) begin
          drop <= 1'b0;
        end
        if (hs) begin
          state    <= S_WAIT;
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + XLEN'(4);
        end
      end else if (imem_rsp_valid) begin
        state <= S_FETCH;
        drop  <= 1'b0;
      end

      if (push) begin
        buf_inst[wr_ptr] <= imem_rsp_data;
        buf_pc[wr_ptr]   <= req_pc;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? buf_inst[rd_ptr] : 32'h0000_0013;
  assign inst_pc    = inst_valid ? buf_pc[rd_ptr] : '0;
  assign opcode     = inst[6:0];
  assign funct3     = inst[14:12];
  assign funct7     = inst[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          consumed = 0;
  int          lat_fix = 1;
  bit          chk_req = 0;
  logic [31:0] chk_addr = '0;
  int          chk_age = 0;

  function automatic logic [31:0] memword(logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      default: return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: after a restart the delivered stream is the sequential PCs from the target.
  task automatic model_restart(logic [31:0] pc);
    logic [31:0] p;
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      p = pc + 32'(i) * 32'd4;
      exp_q.push_back('{p, memword(p)});
    end
  endtask

  task automatic do_reset(int n);
    rst_n          = 1'b1;
    stall          = 1'b1;
    redirect_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("reset_req_valid", 32'(imem_req_valid), 32'd0);
      if (i > 0) begin
        check("reset_inst_valid", 32'(inst_valid), 32'd0);
        check("reset_inst_pc", inst_pc, 32'd0);
      end
      cyc();
    end
    rst_n = 1'b0;
    model_restart(RESET_PC);
    chk_req  = 1'b1;
    chk_addr = RESET_PC;
    chk_age  = 0;
  endtask

  task automatic do_redirect(logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    stall          = 1'b1;
    model_restart(pc & ~32'd3);
    cyc();
    redirect_valid = 1'b0;
    chk_req  = 1'b1;
    chk_addr = pc & ~32'd3;
    chk_age  = 0;
  endtask

  task automatic wait_req(string name, logic [31:0] addr, int bound);
    bit found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        check(name, imem_req_addr, addr);
        found = 1;
      end else begin
        cyc();
      end
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL %s actual=no_request expected=%h", name, addr);
    end
  endtask

  task automatic wait_hs(logic [31:0] addr, bit any_addr);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && (any_addr || imem_req_addr == addr)) found = 1;
      cyc();
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL wait_handshake actual=none expected=%h", addr);
    end
  endtask

  task automatic wait_inst(string name, logic [31:0] pc);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        check(name, inst_pc, pc);
        found = 1;
      end
      cyc();
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL %s actual=no_inst expected=%h", name, pc);
    end
  endtask

  // Memory responder: one response per accepted request, latency >= 1 cycle.
  initial begin
    bit          pend = 0;
    bit          hs_s;
    logic [31:0] addr_s;
    logic [31:0] paddr = '0;
    int          wait_c = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      hs_s   = imem_req_valid && imem_req_ready;
      addr_s = imem_req_addr;
      if (imem_req_valid) check("req_align", 32'(addr_s[1:0]), 32'd0);
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (hs_s) begin
        check("one_outstanding", 32'(pend), 32'd0);
        pend   = 1;
        paddr  = addr_s;
        wait_c = (lat_fix > 0) ? lat_fix - 1 : $urandom_range(0, 2);
      end
      if (pend) begin
        if (wait_c == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memword(paddr);
          pend           = 0;
        end else begin
          wait_c--;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (inst_valid && !stall) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_empty actual_pc=%h expected=none", inst_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", inst_pc, e.pc);
            check("sb_inst", inst, e.word);
            check("sb_opcode", 32'(opcode), 32'(e.word[6:0]));
            check("sb_funct3", 32'(funct3), 32'(e.word[14:12]));
            check("sb_funct7", 32'(funct7), 32'(e.word[31:25]));
            consumed++;
          end
        end else if (!inst_valid) begin
          check("empty_inst", inst, 32'h0000_0013);
          check("empty_opcode", 32'(opcode), 32'h13);
        end
        if (chk_req) begin
          if (imem_req_valid) begin
            check("first_req_after_restart", imem_req_addr, chk_addr);
            chk_req = 0;
          end else if (++chk_age > 20) begin
            tests++;
            fails++;
            $display("FAIL first_req_after_restart actual=none expected=%h", chk_addr);
            chk_req = 0;
          end
        end
      end
    end
  end

  initial begin
    int          since = 0;
    logic [31:0] tgt;
    rst_n          = 1'b1;
    stall          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;

    // Back-to-back fetch at latency 1
    lat_fix = 1;
    do_reset(3);
    stall = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("seq_req_valid", 32'(imem_req_valid), 32'(c % 2 == 0));
      if (c % 2 == 0) check("seq_req_addr", imem_req_addr, 32'(4 * (c / 2)));
      check("seq_inst_valid", 32'(inst_valid), 32'(c % 2 == 0 && c >= 2));
      cyc();
    end
    repeat (4) cyc();

    // Decode stalled: buffer fills, requests stop
    do_reset(3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        check("full_head_pc", inst_pc, 32'h0);
      end
      cyc();
    end
    stall = 1'b0;
    wait_req("after_full_req", 32'h8, 8);
    repeat (6) cyc();

    // Redirect while waiting for a response
    lat_fix = 2;
    do_reset(3);
    stall = 1'b0;
    wait_hs(32'h4, 0);
    do_redirect(32'h200);
    stall = 1'b0;
    wait_req("redir_in_wait_req", 32'h200, 10);
    wait_inst("redir_in_wait_inst", 32'h200);

    // Redirect coinciding with the response
    lat_fix = 1;
    do_reset(3);
    stall = 1'b0;
    wait_hs(32'h8, 0);
    do_redirect(32'h100);
    stall = 1'b0;
    @(negedge clk);
    check("redir_with_rsp_valid", 32'(imem_req_valid), 32'd1);
    check("redir_with_rsp_addr", imem_req_addr, 32'h100);
    wait_inst("redir_with_rsp_inst", 32'h100);

    // Misaligned target
    do_redirect(32'h102);
    stall = 1'b0;
    wait_req("misaligned_req", 32'h100, 10);
    wait_inst("misaligned_inst", 32'h100);

    // Reset while a response is outstanding
    lat_fix = 2;
    wait_hs(32'h0, 1);
    do_reset(4);
    stall = 1'b0;
    wait_inst("reset_in_wait_inst", RESET_PC);

    // Randomised traffic
    lat_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 9) < 3);
      since++;
      if (since > 12 && ($urandom_range(0, 19) == 0 || since > 250)) begin
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        do_redirect(tgt);
        since = 0;
      end else if (since > 12 && $urandom_range(0, 399) == 0) begin
        do_reset(5);
        since = 0;
      end else begin
        cyc();
      end
    end
    stall = 1'b0;
    repeat (10) cyc();

    tests++;
    if (consumed < 200) begin
      fails++;
      $display("FAIL liveness actual=%0d expected_at_least=200", consumed);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
